// File: rtl/sf_camera_pingpong_writer.sv
`default_nettype none
// ============================================================================
// Module      : sf_camera_pingpong_writer
// Description : Wishbone write-master that streams 32-bit pixel words into two
//               ping-pong frame buffers in external memory, one single-beat
//               write per word, and hands each filled buffer back to the host.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_enable              1 = accept pixels and fill buffers
//   i_base0/1, i_size0/1  buffer base address / size in words
//   i_buf_release[1:0]    pulse: host returns buffer n to the controller
//   i_error_clear         pulse: leave the ERROR state
//   i_pix_valid/data      pixel stream in; o_pix_ready handshake out
//   o_mem_*/i_mem_ack     Wishbone master write port
//   o_buf_ready[1:0]      bit n = buffer n owned by controller
//   o_active_buf          buffer currently selected for filling
//   o_pointer             words written into the active buffer
//   o_buf_done[1:0]       one-cycle pulse when buffer n becomes full
//   o_int                 one-cycle pulse alongside any o_buf_done bit
//   o_error               sticky ack-timeout flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module sf_camera_pingpong_writer #(
    parameter int ADDR_INC    = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [31:0] i_base0,
    input  logic [31:0] i_base1,
    input  logic [31:0] i_size0,
    input  logic [31:0] i_size1,
    input  logic [1:0]  i_buf_release,
    input  logic        i_error_clear,
    input  logic        i_pix_valid,
    input  logic [31:0] i_pix_data,
    output logic        o_pix_ready,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic        i_mem_ack,
    output logic [1:0]  o_buf_ready,
    output logic        o_active_buf,
    output logic [31:0] o_pointer,
    output logic [1:0]  o_buf_done,
    output logic        o_int,
    output logic        o_error
);

    localparam logic [31:0] c_addr_inc     = 32'(ADDR_INC);
    localparam logic [31:0] c_timeout_last = 32'(ACK_TIMEOUT - 1);
    localparam bit          c_timeout_en   = (ACK_TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WRITE     = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_base;
    logic [31:0] r_size;
    logic [31:0] r_pointer;
    logic [31:0] r_timer;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_strobe;
    logic        r_active;
    logic [1:0]  r_buf_ready;
    logic [1:0]  r_done;
    logic        r_int;
    logic        r_error;
    // Set when a fill is paused by i_enable=0 so that the next SELECT
    // resumes the same buffer at the same pointer instead of restarting.
    logic        r_resume;

    logic [31:0] w_sel_base;
    logic [31:0] w_sel_size;
    logic [31:0] w_ptr_inc;
    logic        w_accept;
    logic        w_last;
    logic        w_timeout;
    logic        w_filling;
    logic        w_sel_ok;
    logic [1:0]  w_release_ok;

    assign w_sel_base = r_active ? i_base1 : i_base0;
    assign w_sel_size = r_active ? i_size1 : i_size0;
    assign w_ptr_inc  = r_pointer + 32'd1;
    assign w_accept   = (r_state == ST_WAIT_DATA) && i_pix_valid;
    assign w_last     = (w_ptr_inc == r_size);
    assign w_timeout  = c_timeout_en && (r_timer == c_timeout_last);
    assign w_sel_ok   = r_buf_ready[r_active] && (w_sel_size != 32'd0);
    assign w_filling  = (r_state == ST_WAIT_DATA) || (r_state == ST_WRITE) ||
                        (r_state == ST_ERROR);

    // The host may not take back the buffer currently being filled.
    assign w_release_ok[0] = i_buf_release[0] & ~(w_filling & ~r_active);
    assign w_release_ok[1] = i_buf_release[1] & ~(w_filling &  r_active);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_resume || w_sel_ok) begin
                    w_state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (w_accept) begin
                    w_state_next = ST_WRITE;
                end else if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_mem_ack) begin
                    w_state_next = w_last ? ST_SELECT : ST_WAIT_DATA;
                end else if (w_timeout) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (i_error_clear) begin
                    w_state_next = ST_WAIT_DATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= 32'd0;
            r_size      <= 32'd0;
            r_pointer   <= 32'd0;
            r_timer     <= 32'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
            r_buf_ready <= 2'b11;
            r_done      <= 2'b00;
            r_int       <= 1'b0;
            r_error     <= 1'b0;
            r_resume    <= 1'b0;
        end else begin
            r_done      <= 2'b00;
            r_int       <= 1'b0;
            r_buf_ready <= r_buf_ready | w_release_ok;

            case (r_state)
                ST_SELECT: begin
                    if (i_enable) begin
                        if (r_resume) begin
                            r_resume <= 1'b0;
                        end else if (r_buf_ready[r_active]) begin
                            if (w_sel_size != 32'd0) begin
                                r_base    <= w_sel_base;
                                r_size    <= w_sel_size;
                                r_pointer <= 32'd0;
                            end else begin
                                // Zero-sized buffer is skipped silently.
                                r_active <= ~r_active;
                            end
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_accept) begin
                        r_adr    <= r_base + (r_pointer * c_addr_inc);
                        r_dat    <= i_pix_data;
                        r_strobe <= 1'b1;
                        r_timer  <= 32'd0;
                    end else if (!i_enable) begin
                        r_resume <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        r_strobe  <= 1'b0;
                        r_pointer <= w_ptr_inc;
                        if (w_last) begin
                            // Overrides any same-cycle release of this buffer.
                            r_buf_ready[r_active] <= 1'b0;
                            r_done   <= r_active ? 2'b10 : 2'b01;
                            r_int    <= 1'b1;
                            r_active <= ~r_active;
                        end
                    end else if (w_timeout) begin
                        // Word is dropped; pointer stays so the retry
                        // lands on the same address.
                        r_strobe <= 1'b0;
                        r_error  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_ERROR: begin
                    if (i_error_clear) begin
                        r_error <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pix_ready  = (r_state == ST_WAIT_DATA);
    assign o_mem_we     = r_strobe;
    assign o_mem_stb    = r_strobe;
    assign o_mem_cyc    = r_strobe;
    assign o_mem_sel    = 4'hF;
    assign o_mem_adr    = r_adr;
    assign o_mem_dat    = r_dat;
    assign o_buf_ready  = r_buf_ready;
    assign o_active_buf = r_active;
    assign o_pointer    = r_pointer;
    assign o_buf_done   = r_done;
    assign o_int        = r_int;
    assign o_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sf_camera_pingpong_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sf_camera_pingpong_writer
// Description : Directed self-checking bench for sf_camera_pingpong_writer.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sf_camera_pingpong_writer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] base0, base1, size0, size1;
    logic [1:0]  buf_release;
    logic        error_clear;
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        pix_ready;
    logic        mem_we, mem_stb, mem_cyc;
    logic [3:0]  mem_sel;
    logic [31:0] mem_adr, mem_dat;
    logic        mem_ack;
    logic [1:0]  buf_ready;
    logic        active_buf;
    logic [31:0] pointer;
    logic [1:0]  buf_done;
    logic        irq;
    logic        error;

    int errors = 0;
    int checks = 0;
    logic done0_seen;

    sf_camera_pingpong_writer #(
        .ADDR_INC    (1),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_base0       (base0),
        .i_base1       (base1),
        .i_size0       (size0),
        .i_size1       (size1),
        .i_buf_release (buf_release),
        .i_error_clear (error_clear),
        .i_pix_valid   (pix_valid),
        .i_pix_data    (pix_data),
        .o_pix_ready   (pix_ready),
        .o_mem_we      (mem_we),
        .o_mem_stb     (mem_stb),
        .o_mem_cyc     (mem_cyc),
        .o_mem_sel     (mem_sel),
        .o_mem_adr     (mem_adr),
        .o_mem_dat     (mem_dat),
        .i_mem_ack     (mem_ack),
        .o_buf_ready   (buf_ready),
        .o_active_buf  (active_buf),
        .o_pointer     (pointer),
        .o_buf_done    (buf_done),
        .o_int         (irq),
        .o_error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (buf_done[0]) done0_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word and wait for it to be accepted; ends at the falling
    // edge after the accepting clock, with pix_valid removed.
    task automatic start_word(input logic [31:0] d);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        while (!pix_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 128'(pix_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // One full word: strobes must be stable for `delay` cycles, the slave
    // acks on the last of them, then strobes drop and pointer advances.
    task automatic send_word(input logic [31:0] d, input logic [31:0] adr,
                             input int delay, input logic [31:0] exp_ptr);
        start_word(d);
        for (int k = 1; k <= delay; k++) begin
            check("write_hold", {mem_cyc, mem_stb, mem_we, mem_sel, mem_adr, mem_dat},
                  {3'b111, 4'hF, adr, d});
            if (k == delay) mem_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("write_end", {mem_cyc, mem_stb, mem_we, pointer}, {3'b000, exp_ptr});
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        base0       = 32'h1000;
        base1       = 32'h2000;
        size0       = 32'd4;
        size1       = 32'd4;
        buf_release = 2'b00;
        error_clear = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 32'h0;
        mem_ack     = 1'b0;
        done0_seen  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_dat, pix_ready,
               buf_ready, active_buf, pointer, buf_done, irq, error},
              {3'b000, 4'hF, 32'h0, 32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0});
        rst    = 1'b0;
        enable = 1'b1;

        // Fill buffer 0 then buffer 1, single-cycle ack.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] adr;
            logic [2:0]  exp_done;
            adr = (i < 4) ? (32'h1000 + 32'(i)) : (32'h2000 + 32'(i - 4));
            send_word(32'hA5A5_0000 + 32'(i), adr, 1, 32'((i % 4) + 1));
            exp_done = (i == 3) ? 3'b011 : (i == 7) ? 3'b101 : 3'b000;
            check("done_pulse", {buf_done, irq}, exp_done);
            if (i == 3) check("bufready_after_b0", {buf_ready, active_buf}, {2'b10, 1'b1});
        end
        check("bufready_after_b1", {buf_ready, active_buf}, {2'b00, 1'b0});
        repeat (5) @(negedge clk);
        check("backpressure", {pix_ready, mem_cyc, buf_done, irq}, 5'b0);

        // Host returns buffer 0.
        buf_release = 2'b01;
        @(negedge clk);
        buf_release = 2'b00;
        check("release_b0", buf_ready, 2'b01);
        @(negedge clk);
        check("restart_ptr", {pix_ready, active_buf, pointer}, {1'b1, 1'b0, 32'h0});

        // Slow slave: ack after 5 cycles.
        send_word(32'hB0B0_0001, 32'h1000, 5, 32'd1);

        // Releasing the buffer under fill is ignored; the other one is taken.
        buf_release = 2'b11;
        @(negedge clk);
        buf_release = 2'b00;
        check("release_while_fill", {buf_ready, active_buf, pointer}, {2'b11, 1'b0, 32'd1});

        // No ack: abort after 16 cycles of strobe.
        start_word(32'hC0C0_0002);
        for (int k = 1; k <= 16; k++) begin
            check("timeout_hold", {mem_cyc, mem_stb, mem_adr, mem_dat},
                  {2'b11, 32'h1001, 32'hC0C0_0002});
            @(posedge clk);
            @(negedge clk);
        end
        check("timeout_abort", {mem_cyc, mem_stb, error, pix_ready, pointer},
              {4'b0010, 32'd1});
        repeat (3) @(negedge clk);
        check("error_sticky", {error, pix_ready}, 2'b10);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        check("error_clear", {error, pix_ready}, 2'b01);
        send_word(32'hC1C1_0003, 32'h1001, 1, 32'd2);

        // Reset in the middle of a write.
        start_word(32'hD0D0_0004);
        check("pre_reset_write", {mem_cyc, mem_adr}, {1'b1, 32'h1002});
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_write", {mem_cyc, mem_stb, mem_we, buf_ready, active_buf, pointer, error},
              {3'b000, 2'b11, 1'b0, 32'h0, 1'b0});
        size0      = 32'd0;
        done0_seen = 1'b0;
        rst        = 1'b0;

        // Zero-sized buffer 0: everything lands in buffer 1.
        for (int i = 0; i < 4; i++) begin
            send_word(32'hE0E0_0000 + 32'(i), 32'h2000 + 32'(i), 1, 32'(i + 1));
            check("size0_done", {buf_done, irq}, (i == 3) ? 3'b101 : 3'b000);
        end
        repeat (4) @(negedge clk);
        check("size0_stall", {buf_ready, active_buf, pix_ready}, {2'b01, 1'b1, 1'b0});
        check("size0_no_done0", 128'(done0_seen), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
